// File: rtl/game_sequencer_fsm.sv
// Round sequencer for the obstacle game: steps obstacle rows on an internal timer,
// keeps score, speeds up each passed round and resolves the game endings.
module game_sequencer_fsm #(
  parameter int POS_STEPS   = 8,
  parameter int STEP_CYCLES = 16,
  parameter int MIN_CYCLES  = 4,
  parameter int SPEEDUP     = 1,
  parameter int SCORE_W     = 10,
  parameter int WIN_SCORE   = 30
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start_game,
  input  logic                 restart,
  input  logic                 pause,
  input  logic                 crash,
  input  logic                 time_up,
  input  logic                 game_ok,
  output logic [POS_STEPS-1:0] position,
  output logic                 ld_new_obstacle,
  output logic                 check_state,
  output logic                 score_inc,
  output logic [SCORE_W-1:0]   score,
  output logic                 move_en,
  output logic                 counter_clear,
  output logic                 start_screen,
  output logic                 game_screen,
  output logic                 end_screen,
  output logic                 timeup_screen,
  output logic                 win_screen
);
  localparam int POS_W = $clog2(POS_STEPS);
  localparam int CNT_W = $clog2(STEP_CYCLES + 1);
  localparam logic [POS_W-1:0]   POS_LAST  = POS_W'(POS_STEPS - 1);
  localparam logic [CNT_W-1:0]   PER_INIT  = CNT_W'(STEP_CYCLES);
  localparam logic [CNT_W-1:0]   PER_MIN   = CNT_W'(MIN_CYCLES);
  localparam logic [SCORE_W:0]   WIN_V     = (SCORE_W+1)'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_RUN, S_CHECK, S_OVER, S_TIMEOVER, S_WIN, S_RSTWAIT
  } state_e;

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   tick_q, tick_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               ld_q, ld_d;
  logic [SCORE_W:0]   score_p1;
  logic               step_done;

  assign score_p1  = {1'b0, score_q} + {{SCORE_W{1'b0}}, 1'b1};
  assign step_done = (tick_q == period_q - {{(CNT_W-1){1'b0}}, 1'b1});

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      score_q  <= '0;
      period_q <= PER_INIT;
      tick_q   <= '0;
      pos_q    <= '0;
      ld_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      period_q <= period_d;
      tick_q   <= tick_d;
      pos_q    <= pos_d;
      ld_q     <= ld_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    period_d  = period_q;
    tick_d    = tick_q;
    pos_d     = pos_q;
    ld_d      = 1'b0;
    score_inc = 1'b0;
    unique case (state_q)
      S_IDLE: if (start_game) state_d = S_ARM;
      S_ARM: begin
        if (restart) state_d = S_RSTWAIT;
        else if (!start_game) begin
          state_d = S_RUN;
          pos_d   = '0;
          tick_d  = '0;
          ld_d    = 1'b1;
        end
      end
      S_RUN: begin
        // Abort conditions win over a step finishing in the same cycle.
        if (restart)      state_d = S_RSTWAIT;
        else if (crash)   state_d = S_OVER;
        else if (time_up) state_d = S_TIMEOVER;
        else if (!pause) begin
          if (step_done) begin
            tick_d = '0;
            if (pos_q == POS_LAST) state_d = S_CHECK;
            else                   pos_d   = pos_q + 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_CHECK: begin
        if (restart)      state_d = S_RSTWAIT;
        else if (crash)   state_d = S_OVER;
        else if (time_up) state_d = S_TIMEOVER;
        else if (!game_ok) state_d = S_OVER;
        else begin
          score_inc = 1'b1;
          score_d   = score_p1[SCORE_W] ? score_q : score_p1[SCORE_W-1:0];
          if (score_p1 >= WIN_V) state_d = S_WIN;
          else begin
            state_d = S_RUN;
            pos_d   = '0;
            tick_d  = '0;
            ld_d    = 1'b1;
            // Compare before subtracting so the period can never wrap.
            if (int'(period_q) >= MIN_CYCLES + SPEEDUP)
              period_d = period_q - CNT_W'(SPEEDUP);
            else
              period_d = PER_MIN;
          end
        end
      end
      S_OVER, S_TIMEOVER, S_WIN: if (restart) state_d = S_RSTWAIT;
      S_RSTWAIT: if (!restart) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Clearing on entry makes IDLE show a fresh game from its first cycle.
    if (state_d == S_IDLE) begin
      score_d  = '0;
      period_d = PER_INIT;
      tick_d   = '0;
      pos_d    = '0;
    end
  end

  assign position        = (state_q == S_RUN) ? ({{(POS_STEPS-1){1'b0}}, 1'b1} << pos_q) : '0;
  assign ld_new_obstacle = ld_q;
  assign check_state     = (state_q == S_CHECK);
  assign score           = score_q;
  assign move_en         = ((state_q == S_RUN) || (state_q == S_CHECK)) && !pause;
  assign counter_clear   = (state_q == S_IDLE) || (state_q == S_RSTWAIT);
  assign start_screen    = (state_q == S_IDLE) || (state_q == S_RSTWAIT);
  assign game_screen     = (state_q == S_ARM) || (state_q == S_RUN) || (state_q == S_CHECK);
  assign end_screen      = (state_q == S_OVER);
  assign timeup_screen   = (state_q == S_TIMEOVER);
  assign win_screen      = (state_q == S_WIN);
endmodule

// File: tb/tb_game_sequencer_fsm.sv
// Directed bench for game_sequencer_fsm: a WIN_SCORE=2 instance for round/ending
// behaviour and a WIN_SCORE=10 instance sharing inputs for the speed-up floor.
module tb_game_sequencer_fsm;
  logic clk = 1'b0;
  logic resetn, start_game, restart, pause, crash, time_up, game_ok;
  logic [3:0] position, position2;
  logic [9:0] score, score2;
  logic ld, chk_st, sinc, move_en, cclr, s_start, s_game, s_end, s_tup, s_win;
  logic ld2, chk_st2, sinc2, move_en2, cclr2, s_start2, s_game2, s_end2, s_tup2, s_win2;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  game_sequencer_fsm #(.POS_STEPS(4), .STEP_CYCLES(4), .MIN_CYCLES(2), .SPEEDUP(1),
                       .SCORE_W(10), .WIN_SCORE(2)) u_dut (
    .clk(clk), .resetn(resetn), .start_game(start_game), .restart(restart), .pause(pause),
    .crash(crash), .time_up(time_up), .game_ok(game_ok), .position(position),
    .ld_new_obstacle(ld), .check_state(chk_st), .score_inc(sinc), .score(score),
    .move_en(move_en), .counter_clear(cclr), .start_screen(s_start), .game_screen(s_game),
    .end_screen(s_end), .timeup_screen(s_tup), .win_screen(s_win));

  game_sequencer_fsm #(.POS_STEPS(4), .STEP_CYCLES(4), .MIN_CYCLES(2), .SPEEDUP(1),
                       .SCORE_W(10), .WIN_SCORE(10)) u_dut2 (
    .clk(clk), .resetn(resetn), .start_game(start_game), .restart(restart), .pause(pause),
    .crash(crash), .time_up(time_up), .game_ok(game_ok), .position(position2),
    .ld_new_obstacle(ld2), .check_state(chk_st2), .score_inc(sinc2), .score(score2),
    .move_en(move_en2), .counter_clear(cclr2), .start_screen(s_start2), .game_screen(s_game2),
    .end_screen(s_end2), .timeup_screen(s_tup2), .win_screen(s_win2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in its first RUN cycle.
  task automatic start_run();
    start_game = 1'b1; cyc(1);
    start_game = 1'b0; cyc(1);
  endtask

  task automatic back_to_idle();
    restart = 1'b1; cyc(1);
    restart = 1'b0; cyc(1);
  endtask

  initial begin
    int n;
    resetn = 1'b0; start_game = 0; restart = 0; pause = 0; crash = 0; time_up = 0; game_ok = 1;
    cyc(2);
    chk("rst_start_screen", s_start, 1);
    chk("rst_cclr", cclr, 1);
    chk("rst_score", score, 0);
    chk("rst_position", position, 0);
    chk("rst_outs", {ld, chk_st, sinc, move_en, s_game, s_end, s_tup, s_win}, 0);
    resetn = 1'b1; cyc(1);
    chk("idle_hold", s_start, 1);
    start_game = 1'b1; cyc(1);
    chk("arm_game_screen", {s_game, s_start}, 2'b10);
    chk("arm_position", position, 0);
    start_game = 1'b0; cyc(1);
    chk("run1_pos", position, 4'b0001);
    chk("run1_ld", ld, 1);
    chk("run1_move_en", move_en, 1);

    // Round 1: 4 cycles per step
    cyc(1); chk("run2_ld_off", ld, 0);
    cyc(2); chk("run4_pos", position, 4'b0001);
    cyc(1); chk("run5_pos", position, 4'b0010);
    cyc(11); chk("run16_pos", position, 4'b1000);
    cyc(1);
    chk("chk1_state", chk_st, 1);
    chk("chk1_position", position, 0);
    chk("chk1_score_inc", sinc, 1);
    chk("chk1_score_old", score, 0);
    cyc(1);
    chk("r2_score", score, 1);
    chk("r2_ld", ld, 1);
    chk("r2_sinc_off", sinc, 0);
    chk("r2_pos", position, 4'b0001);
    // Round 2: 3 cycles per step
    cyc(2); chk("r2c3_pos", position, 4'b0001);
    cyc(1); chk("r2c4_pos", position, 4'b0010);
    cyc(8); chk("r2c12_pos", position, 4'b1000);
    cyc(1); chk("chk2_state", chk_st, 1);
    cyc(1);
    chk("win_screen", {s_win, s_game, move_en}, 3'b100);
    chk("win_score", score, 2);
    restart = 1'b1; cyc(1);
    chk("rw_cclr", {cclr, s_start, move_en}, 3'b110);
    restart = 1'b0; cyc(1);
    chk("idle_score", score, 0);
    chk("idle_screen", s_start, 1);

    // Pause for 7 edges starting at RUN cycle 2; game_ok=0 ends the round
    start_run(); cyc(1);
    pause = 1'b1; cyc(1);
    chk("pause_move_en", move_en, 0);
    chk("pause_pos", position, 4'b0001);
    chk("pause_screen", s_game, 1);
    cyc(6);
    chk("pause_end_pos", position, 4'b0001);
    pause = 1'b0; game_ok = 1'b0;
    cyc(2); chk("pause_r4_pos", position, 4'b0001);
    cyc(1); chk("pause_r5_pos", position, 4'b0010);
    cyc(11); chk("pause_r16_pos", {position, chk_st}, 5'b10000);
    cyc(1);
    chk("pause_check", chk_st, 1);
    chk("bad_sinc", sinc, 0);
    cyc(1);
    chk("bad_over", s_end, 1);
    chk("bad_score", score, 0);
    game_ok = 1'b1;
    back_to_idle();

    // Endings
    start_run(); cyc(8);
    chk("crash_pos2", position, 4'b0100);
    crash = 1'b1; cyc(1); crash = 1'b0;
    chk("crash_over", {s_end, s_game, position}, 6'b100000);
    back_to_idle();
    start_run(); cyc(2);
    crash = 1'b1; time_up = 1'b1; cyc(1); crash = 1'b0; time_up = 1'b0;
    chk("both_over", {s_end, s_tup}, 2'b10);
    back_to_idle();
    start_run(); cyc(3);
    time_up = 1'b1; cyc(1); time_up = 1'b0;
    chk("timeover", {s_tup, s_end}, 2'b10);
    back_to_idle();
    start_run(); cyc(3);
    crash = 1'b1; pause = 1'b1; cyc(1); crash = 1'b0; pause = 1'b0;
    chk("crash_step_pause", s_end, 1);
    back_to_idle();

    // Restart held 3 cycles with a nonzero score
    start_run(); cyc(16);
    chk("rs_check", chk_st, 1);
    cyc(1); chk("rs_score1", score, 1);
    restart = 1'b1; cyc(1);
    chk("rs_wait", {cclr, s_start}, 2'b11);
    cyc(2);
    chk("rs_wait_hold", cclr, 1);
    restart = 1'b0; cyc(1);
    chk("rs_idle", {s_start, s_game}, 2'b10);
    chk("rs_idle_score", score, 0);

    // Asynchronous reset mid-round
    start_run(); cyc(5);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst", {s_start, s_game, position}, 6'b100000);
    chk("async_ld", ld, 0);
    cyc(1); resetn = 1'b1; cyc(1);

    // Speed-up floor on the WIN_SCORE=10 instance: 16, 12, 8, 8 RUN cycles
    start_run();
    for (int r = 0; r < 4; r++) begin
      n = 0;
      while (!chk_st2 && n < 100) begin cyc(1); n++; end
      chk($sformatf("round%0d_len", r), n, (r == 0) ? 16 : (r == 1) ? 12 : 8);
      cyc(1);
    end
    chk("floor_score", score2, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
